// File: rtl/decide_var_scanner_pkg.sv
// Shared constants and FSM encoding for the decision-variable scanner.
// Score bank geometry: NUM_VARS variables read as groups of LANES lanes.
package decide_var_scanner_pkg;

   localparam int unsigned NUM_VARS   = 64;
   localparam int unsigned WIDTH      = 5;
   localparam int unsigned VAR_W      = 6;
   localparam int unsigned GROUP_W    = 3;
   localparam int unsigned LANES      = 8;
   localparam int unsigned LANE_W     = 3;
   localparam int unsigned NUM_GROUPS = NUM_VARS / LANES;
   // Tree operand: {unassigned, score} so a masked lane always loses.
   localparam int unsigned TREE_W     = WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/max_in_8_datas.sv
// Maximum of eight W-bit operands.
// Ports: data_i  - eight packed operands, lane k at [k*W +: W]
//        data_o  - largest operand
//        index_o - one-hot lane of the winner; lower lane wins on equality
module max_in_8_datas #(
   parameter int unsigned W = 6
) (
   input  logic [8*W-1:0] data_i,
   output logic [W-1:0]   data_o,
   output logic [7:0]     index_o
);

   // Strict compare keeps the lowest lane among equal maxima.
   always_comb begin
      data_o  = data_i[W-1:0];
      index_o = 8'b0000_0001;
      for (int k = 1; k < 8; k++) begin
         if (data_i[k*W +: W] > data_o) begin
            data_o  = data_i[k*W +: W];
            index_o = 8'(1) << k;
         end
      end
   end

endmodule

// File: rtl/onehot8_to_bin.sv
// 8-bit one-hot to 3-bit binary index; all-zero input maps to 0.
// Ports: onehot_i - one-hot vector, bin_o - encoded index
module onehot8_to_bin (
   input  logic [7:0] onehot_i,
   output logic [2:0] bin_o
);

   always_comb begin
      bin_o = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (onehot_i[k]) begin
            bin_o = bin_o | 3'(k);
         end
      end
   end

endmodule

// File: rtl/decide_var_scanner.sv
// Sequential front end of the decision-variable selector: streams the score
// bank one group of 8 lanes per cycle and keeps the best unassigned variable.
// Ports: clk, rst (sync, active-high); start_i scan request (IDLE only);
//        rd_en_o/rd_group_o bank read; rd_scores_i/rd_unassigned_i read data
//        one cycle later; busy_o, done_o pulse, found_o, max_var_o, max_score_o.
module decide_var_scanner
   import decide_var_scanner_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   output logic                     rd_en_o,
   output logic [GROUP_W-1:0]       rd_group_o,
   input  logic [LANES*WIDTH-1:0]   rd_scores_i,
   input  logic [LANES-1:0]         rd_unassigned_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     found_o,
   output logic [VAR_W-1:0]         max_var_o,
   output logic [WIDTH-1:0]         max_score_o
);

   localparam logic [GROUP_W-1:0] GROUP_LAST = GROUP_W'(NUM_GROUPS - 1);

   state_e               state_q, state_d;
   logic                 rd_en_q, rd_en_d;
   logic [GROUP_W-1:0]   rd_group_q, rd_group_d;
   logic                 rd_vld_q, rd_vld_d;
   logic [GROUP_W-1:0]   rd_grp_pipe_q, rd_grp_pipe_d;
   logic                 best_vld_q, best_vld_d;
   logic [VAR_W-1:0]     best_var_q, best_var_d;
   logic [WIDTH-1:0]     best_score_q, best_score_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 found_q, found_d;
   logic [VAR_W-1:0]     max_var_q, max_var_d;
   logic [WIDTH-1:0]     max_score_q, max_score_d;

   logic [LANES*TREE_W-1:0] tree_in;
   logic [TREE_W-1:0]       tree_data;
   logic [LANES-1:0]        tree_index;
   logic [LANE_W-1:0]       grp_lane;
   logic                    grp_cand;
   logic [WIDTH-1:0]        grp_score;
   logic [VAR_W-1:0]        grp_var;

   // Unassigned bit on top of each lane so candidates outrank masked lanes.
   always_comb begin
      tree_in = '0;
      for (int k = 0; k < LANES; k++) begin
         tree_in[k*TREE_W +: TREE_W] = {rd_unassigned_i[k], rd_scores_i[k*WIDTH +: WIDTH]};
      end
   end

   max_in_8_datas #(.W(TREE_W)) u_max (
      .data_i  (tree_in),
      .data_o  (tree_data),
      .index_o (tree_index)
   );

   onehot8_to_bin u_enc (
      .onehot_i (tree_index),
      .bin_o    (grp_lane)
   );

   assign grp_cand  = tree_data[WIDTH];
   assign grp_score = tree_data[WIDTH-1:0];
   assign grp_var   = {rd_grp_pipe_q, grp_lane};

   // Next-state, read address, running best and result registers.
   always_comb begin
      state_d       = state_q;
      rd_en_d       = 1'b0;
      rd_group_d    = rd_group_q;
      rd_vld_d      = rd_en_q;
      rd_grp_pipe_d = rd_group_q;
      best_vld_d    = best_vld_q;
      best_var_d    = best_var_q;
      best_score_d  = best_score_q;
      found_d       = found_q;
      max_var_d     = max_var_q;
      max_score_d   = max_score_q;

      // Strict compare across groups keeps the earlier (lower) index on ties.
      if (rd_vld_q && grp_cand && (!best_vld_q || (grp_score > best_score_q))) begin
         best_vld_d   = 1'b1;
         best_var_d   = grp_var;
         best_score_d = grp_score;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d      = ST_SCAN;
               rd_en_d      = 1'b1;
               rd_group_d   = '0;
               best_vld_d   = 1'b0;
               best_var_d   = '0;
               best_score_d = '0;
               found_d      = 1'b0;
               max_var_d    = '0;
               max_score_d  = '0;
            end
         end
         ST_SCAN: begin
            if (rd_group_q == GROUP_LAST) begin
               state_d    = ST_DRAIN;
               rd_group_d = '0;
            end else begin
               rd_en_d    = 1'b1;
               rd_group_d = rd_group_q + GROUP_W'(1);
            end
         end
         ST_DRAIN: begin
            // Result includes the last group being consumed this cycle.
            state_d     = ST_DONE;
            found_d     = best_vld_d;
            max_var_d   = best_var_d;
            max_score_d = best_score_d;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         rd_en_q       <= 1'b0;
         rd_group_q    <= '0;
         rd_vld_q      <= 1'b0;
         rd_grp_pipe_q <= '0;
         best_vld_q    <= 1'b0;
         best_var_q    <= '0;
         best_score_q  <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         found_q       <= 1'b0;
         max_var_q     <= '0;
         max_score_q   <= '0;
      end else begin
         state_q       <= state_d;
         rd_en_q       <= rd_en_d;
         rd_group_q    <= rd_group_d;
         rd_vld_q      <= rd_vld_d;
         rd_grp_pipe_q <= rd_grp_pipe_d;
         best_vld_q    <= best_vld_d;
         best_var_q    <= best_var_d;
         best_score_q  <= best_score_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         found_q       <= found_d;
         max_var_q     <= max_var_d;
         max_score_q   <= max_score_d;
      end
   end

   assign rd_en_o     = rd_en_q;
   assign rd_group_o  = rd_group_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign found_o     = found_q;
   assign max_var_o   = max_var_q;
   assign max_score_o = max_score_q;

endmodule

// File: tb/tb_decide_var_scanner.sv
// Bench for decide_var_scanner: a score bank that answers reads one cycle
// later, a cycle-level reference model, a per-cycle compare process and
// directed scenarios with hand-computed expectations.
module tb_decide_var_scanner;
   import decide_var_scanner_pkg::*;

   localparam int DONE_T = NUM_GROUPS + 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   start_i;
   logic                   rd_en_o;
   logic [GROUP_W-1:0]     rd_group_o;
   logic [LANES*WIDTH-1:0] rd_scores_i;
   logic [LANES-1:0]       rd_unassigned_i;
   logic                   busy_o;
   logic                   done_o;
   logic                   found_o;
   logic [VAR_W-1:0]       max_var_o;
   logic [WIDTH-1:0]       max_score_o;

   always #5 clk = ~clk;

   decide_var_scanner dut (
      .clk             (clk),
      .rst             (rst),
      .start_i         (start_i),
      .rd_en_o         (rd_en_o),
      .rd_group_o      (rd_group_o),
      .rd_scores_i     (rd_scores_i),
      .rd_unassigned_i (rd_unassigned_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .found_o         (found_o),
      .max_var_o       (max_var_o),
      .max_score_o     (max_score_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int unsigned bank_score [NUM_VARS];
   bit          bank_un    [NUM_VARS];

   // Model: t = cycles since start accepted (0 = idle).
   int t = 0;
   bit exp_found = 0;
   int exp_var = 0, exp_score = 0;
   bit res_found;
   int res_var, res_score;
   bit chk_en = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Highest score among unassigned variables; lowest index on ties.
   function automatic void model_result(output bit f, output int v, output int s);
      f = 0; v = 0; s = 0;
      for (int i = 0; i < NUM_VARS; i++) begin
         if (bank_un[i] && (!f || int'(bank_score[i]) > s)) begin
            f = 1; v = i; s = int'(bank_score[i]);
         end
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         t = 0; exp_found = 0; exp_var = 0; exp_score = 0;
      end else if (t == 0) begin
         if (start_i) begin
            t = 1; exp_found = 0; exp_var = 0; exp_score = 0;
            model_result(res_found, res_var, res_score);
         end
      end else begin
         t = (t == DONE_T) ? 0 : t + 1;
         if (t == DONE_T) begin
            exp_found = res_found; exp_var = res_var; exp_score = res_score;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("rd_en",     32'(rd_en_o),     32'(t >= 1 && t <= NUM_GROUPS));
         if (t >= 1 && t <= NUM_GROUPS) check("rd_group", 32'(rd_group_o), 32'(t - 1));
         check("busy",      32'(busy_o),      32'(t != 0));
         check("done",      32'(done_o),      32'(t == DONE_T));
         check("found",     32'(found_o),     32'(exp_found));
         check("max_var",   32'(max_var_o),   32'(exp_var));
         check("max_score", 32'(max_score_o), 32'(exp_score));
      end
   end

   // Score bank: data for a read appears during the following cycle; noise otherwise.
   initial begin
      bit pend_vld;
      int pend_grp;
      pend_vld = 0; pend_grp = 0;
      rd_scores_i = '0; rd_unassigned_i = '0;
      forever begin
         @(negedge clk);
         if (pend_vld) begin
            for (int k = 0; k < LANES; k++) begin
               rd_scores_i[k*WIDTH +: WIDTH] = WIDTH'(bank_score[pend_grp*LANES + k]);
               rd_unassigned_i[k]            = bank_un[pend_grp*LANES + k];
            end
         end else begin
            rd_scores_i     = LANES*WIDTH'({$urandom, $urandom});
            rd_unassigned_i = LANES'($urandom);
         end
         pend_vld = (rd_en_o === 1'b1);
         pend_grp = int'(rd_group_o);
      end
   end

   task automatic fill(input int max_s, input int un_pct);
      for (int i = 0; i < NUM_VARS; i++) begin
         bank_score[i] = $urandom_range(max_s, 0);
         bank_un[i]    = ($urandom_range(99, 0) < un_pct);
      end
   endtask

   // One scan from IDLE; optional literal expectations at the done cycle.
   task automatic run(input string tag, input bit lit, input int lf, input int lv, input int ls);
      int lat;
      lat = -1;
      @(negedge clk) start_i = 1'b1;
      @(negedge clk) start_i = 1'b0;
      for (int i = 2; i <= 30; i++) begin
         @(negedge clk);
         if (done_o === 1'b1) begin lat = i; break; end
      end
      check({tag, "_latency"}, 32'(lat), 32'(DONE_T));
      if (lit) begin
         check({tag, "_found"}, 32'(found_o),     32'(lf));
         check({tag, "_var"},   32'(max_var_o),   32'(lv));
         check({tag, "_score"}, 32'(max_score_o), 32'(ls));
      end
      @(negedge clk);
   endtask

   initial begin
      int cnt;
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      int cnt;
      rst = 1'b1; start_i = 1'b0;
      fill(31, 50);
      @(posedge clk);
      @(negedge clk);
      chk_en = 1;
      check("reset_busy",  32'(busy_o),  32'(0));
      check("reset_rd_en", 32'(rd_en_o), 32'(0));
      check("reset_found", 32'(found_o), 32'(0));
      @(negedge clk) rst = 1'b0;

      fill(31, 0);
      run("all_masked", 1, 0, 0, 0);

      fill(31, 0);
      for (int i = 0; i < NUM_VARS; i++) bank_score[i] = 31;
      bank_un[12] = 1; bank_score[12] = 0;
      run("only_v12", 1, 1, 12, 0);

      for (int i = 0; i < NUM_VARS; i++) begin bank_un[i] = 1; bank_score[i] = $urandom_range(19, 0); end
      bank_score[37] = 20;
      run("v37", 1, 1, 37, 20);

      for (int i = 0; i < NUM_VARS; i++) begin bank_un[i] = 1; bank_score[i] = $urandom_range(30, 0); end
      bank_score[5] = 31; bank_score[50] = 31;
      run("xgroup_tie", 1, 1, 5, 31);

      for (int i = 0; i < NUM_VARS; i++) begin bank_un[i] = 1; bank_score[i] = $urandom_range(30, 0); end
      bank_score[42] = 31; bank_score[46] = 31;
      run("ingroup_tie", 1, 1, 42, 31);

      for (int i = 0; i < NUM_VARS; i++) begin bank_un[i] = 1; bank_score[i] = $urandom_range(16, 0); end
      bank_score[63] = 17;
      run("last_lane", 1, 1, 63, 17);

      for (int r = 0; r < 24; r++) begin
         fill((r % 3 == 0) ? 3 : 31, (r % 4 == 0) ? 5 : 60);
         run("random", 0, 0, 0, 0);
      end

      // start_i pulsed mid-scan must not queue a second scan.
      fill(31, 50);
      cnt = 0;
      @(negedge clk) start_i = 1'b1;
      @(negedge clk) start_i = 1'b0;
      for (int i = 2; i <= 25; i++) begin
         @(negedge clk);
         if (i == 4) start_i = 1'b1;
         if (i == 5) start_i = 1'b0;
         if (done_o === 1'b1) cnt++;
      end
      check("single_done", 32'(cnt), 32'(1));

      // Reset mid-scan: back to IDLE, no done.
      fill(31, 50);
      cnt = 0;
      @(negedge clk) start_i = 1'b1;
      @(negedge clk) start_i = 1'b0;
      for (int i = 2; i <= 20; i++) begin
         @(negedge clk);
         if (i == 4) rst = 1'b1;
         if (i == 5) begin
            rst = 1'b0;
            check("rst_busy",  32'(busy_o),  32'(0));
            check("rst_rd_en", 32'(rd_en_o), 32'(0));
            check("rst_found", 32'(found_o), 32'(0));
         end
         if (done_o === 1'b1) cnt++;
      end
      check("rst_no_done", 32'(cnt), 32'(0));

      for (int i = 0; i < NUM_VARS; i++) begin bank_un[i] = 1; bank_score[i] = $urandom_range(19, 0); end
      bank_score[37] = 20;
      run("after_rst", 1, 1, 37, 20);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
